mem_port_arbiter: RTL

Shares the single external memory port between the CPU's instruction-fetch requester and its load/store requester. Each requester uses a valid/ready request channel and a valid/ready response channel. The block keeps one transaction outstanding, latches it, drives the memory handshake, and returns read data to the owning requester. It sits between the multi-cycle CPU core and the memory/bus model.

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch vs. load/store) in front of a single
// memory port; one transaction in flight, read data routed back to its owner.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req_valid,
    output logic              inst_req_ready,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_resp_valid,
    input  logic              inst_resp_ready,
    output logic [31:0]       inst_rdata,

    input  logic              data_req_valid,
    output logic              data_req_ready,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_wen,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_wstrb,
    output logic              data_resp_valid,
    input  logic              data_resp_ready,
    output logic [31:0]       data_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    state_e              state_q;
    owner_e              owner_q;
    owner_e              last_grant_q;
    logic                mem_req_valid_q;
    logic                mem_resp_ready_q;
    logic                inst_resp_valid_q;
    logic                data_resp_valid_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_wen_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [STRB_W-1:0]   mem_wstrb_q;
    logic [DATA_W-1:0]   inst_rdata_q;
    logic [DATA_W-1:0]   data_rdata_q;
    logic                grant_data_c;

    // Tie-break: fixed data priority, or the side that did not win last time.
    always_comb begin
        grant_data_c = data_req_valid;
        if (inst_req_valid && data_req_valid) begin
            grant_data_c = FIXED_PRIO ? 1'b1 : (last_grant_q == OWN_INST);
        end
    end

    assign inst_req_ready = (state_q == IDLE) && inst_req_valid && !grant_data_c;
    assign data_req_ready = (state_q == IDLE) && data_req_valid &&  grant_data_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            owner_q           <= OWN_INST;
            last_grant_q      <= OWN_DATA;
            mem_req_valid_q   <= 1'b0;
            mem_resp_ready_q  <= 1'b0;
            inst_resp_valid_q <= 1'b0;
            data_resp_valid_q <= 1'b0;
            mem_addr_q        <= '0;
            mem_wen_q         <= 1'b0;
            mem_wdata_q       <= '0;
            mem_wstrb_q       <= '0;
            inst_rdata_q      <= '0;
            data_rdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_req_ready) begin
                        mem_addr_q      <= data_addr;
                        mem_wen_q       <= data_wen;
                        mem_wdata_q     <= data_wdata;
                        mem_wstrb_q     <= data_wen ? data_wstrb : STRB_W'(0);
                        owner_q         <= OWN_DATA;
                        last_grant_q    <= OWN_DATA;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= REQ;
                    end else if (inst_req_ready) begin
                        mem_addr_q      <= inst_addr;
                        mem_wen_q       <= 1'b0;
                        mem_wdata_q     <= '0;
                        mem_wstrb_q     <= '0;
                        owner_q         <= OWN_INST;
                        last_grant_q    <= OWN_INST;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q  <= 1'b0;
                        mem_resp_ready_q <= 1'b1;
                        state_q          <= RESP;
                    end
                end
                RESP: begin
                    if (mem_resp_valid) begin
                        mem_resp_ready_q <= 1'b0;
                        if (owner_q == OWN_DATA) begin
                            data_rdata_q      <= mem_rdata;
                            data_resp_valid_q <= 1'b1;
                        end else begin
                            inst_rdata_q      <= mem_rdata;
                            inst_resp_valid_q <= 1'b1;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (owner_q == OWN_DATA && data_resp_ready) begin
                        data_resp_valid_q <= 1'b0;
                        state_q           <= IDLE;
                    end else if (owner_q == OWN_INST && inst_resp_ready) begin
                        inst_resp_valid_q <= 1'b0;
                        state_q           <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign inst_resp_valid = inst_resp_valid_q;
    assign inst_rdata      = inst_rdata_q;
    assign data_resp_valid = data_resp_valid_q;
    assign data_rdata      = data_rdata_q;
    assign mem_req_valid   = mem_req_valid_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wen         = mem_wen_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_wstrb       = mem_wstrb_q;
    assign mem_resp_ready  = mem_resp_ready_q;

endmodule
